// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle between a master and the memory responder.
interface axi_mem_responder_if #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned LEN_WIDTH  = 8
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [LEN_WIDTH-1:0]  awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awvalid;
   logic                  awready;

   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [LEN_WIDTH-1:0]  arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input  bid, bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
      input  rid, rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave endpoint backed by a word-addressed RAM; independent read and write FSMs.
module axi_mem_responder #(
   parameter int unsigned ID_WIDTH       = 4,
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int unsigned LEN_WIDTH      = 8,
   parameter int unsigned MEM_WORDS_LOG2 = 10
) (
   input logic                clk,
   input logic                rst,
   axi_mem_responder_if.slave s_axi
);
   localparam int unsigned OFF    = $clog2(STRB_WIDTH);
   localparam int unsigned SPAN   = MEM_WORDS_LOG2 + OFF;
   localparam int unsigned WORD_W = MEM_WORDS_LOG2;
   localparam int unsigned DEPTH  = 1 << MEM_WORDS_LOG2;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef logic [WORD_W-1:0]    word_t;
   typedef logic [LEN_WIDTH-1:0] len_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   function automatic word_t word_of(input logic [ADDR_WIDTH-1:0] addr);
      return WORD_W'(addr >> OFF);
   endfunction

   function automatic word_t next_word(input word_t w, input logic [1:0] burst, input len_t len);
      word_t m;
      m = WORD_W'(len);
      case (burst)
         2'b00:   return w;
         2'b10:   return (w & ~m) | ((w + WORD_W'(1)) & m);
         default: return w + WORD_W'(1);
      endcase
   endfunction

   function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size,
                                      input logic [1:0] burst, input len_t len);
      logic e;
      e = 1'b0;
      if (size != 3'(OFF)) e = 1'b1;
      if (burst == 2'b11) e = 1'b1;
      if (burst == 2'b10 && !(len == LEN_WIDTH'(1) || len == LEN_WIDTH'(3) ||
                              len == LEN_WIDTH'(7) || len == LEN_WIDTH'(15))) e = 1'b1;
      if ((addr >> SPAN) != '0) e = 1'b1;
      return e;
   endfunction

   // write path state
   w_state_t w_state_q, w_state_d;
   logic [ID_WIDTH-1:0] w_id_q, w_id_d, bid_q, bid_d;
   word_t w_word_q, w_word_d;
   len_t  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic [1:0] w_burst_q, w_burst_d, bresp_q, bresp_d;
   logic w_err_q, w_err_d, awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic w_mism, mem_we;

   // read path state
   r_state_t r_state_q, r_state_d;
   logic [ID_WIDTH-1:0] r_id_q, r_id_d, rid_q, rid_d;
   word_t r_word_q, r_word_d, r_nw;
   len_t  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic [1:0] r_burst_q, r_burst_d, rresp_q, rresp_d;
   logic r_err_q, r_err_d, arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d, ar_err;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   // write FSM next-state and registered-output values
   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_word_d  = w_word_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_burst_d = w_burst_q;
      w_err_d   = w_err_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      mem_we    = 1'b0;
      w_mism    = s_axi.wlast != (w_cnt_q == w_len_q);
      case (w_state_q)
         W_IDLE: if (s_axi.awvalid && awready_q) begin
            w_id_d    = s_axi.awid;
            w_word_d  = word_of(s_axi.awaddr);
            w_len_d   = s_axi.awlen;
            w_burst_d = s_axi.awburst;
            w_err_d   = burst_err(s_axi.awaddr, s_axi.awsize, s_axi.awburst, s_axi.awlen);
            w_cnt_d   = '0;
            awready_d = 1'b0;
            wready_d  = 1'b1;
            w_state_d = W_DATA;
         end
         W_DATA: if (s_axi.wvalid && wready_q) begin
            mem_we   = !w_err_q;
            w_err_d  = w_err_q | w_mism;
            w_word_d = next_word(w_word_q, w_burst_q, w_len_q);
            w_cnt_d  = w_cnt_q + LEN_WIDTH'(1);
            if (w_cnt_q == w_len_q) begin
               wready_d  = 1'b0;
               bvalid_d  = 1'b1;
               bid_d     = w_id_q;
               bresp_d   = (w_err_q | w_mism) ? SLVERR : OKAY;
               w_state_d = W_RESP;
            end
         end
         W_RESP: if (s_axi.bready && bvalid_q) begin
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // read FSM next-state; rdata is loaded from RAM on accept and on each advancing beat
   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_word_d  = r_word_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_burst_d = r_burst_q;
      r_err_d   = r_err_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rid_d     = rid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      r_nw      = next_word(r_word_q, r_burst_q, r_len_q);
      ar_err    = burst_err(s_axi.araddr, s_axi.arsize, s_axi.arburst, s_axi.arlen);
      case (r_state_q)
         R_IDLE: if (s_axi.arvalid && arready_q) begin
            r_id_d    = s_axi.arid;
            r_word_d  = word_of(s_axi.araddr);
            r_len_d   = s_axi.arlen;
            r_burst_d = s_axi.arburst;
            r_err_d   = ar_err;
            r_cnt_d   = '0;
            rdata_d   = ar_err ? '0 : mem[word_of(s_axi.araddr)];
            rid_d     = s_axi.arid;
            rresp_d   = ar_err ? SLVERR : OKAY;
            rlast_d   = (s_axi.arlen == '0);
            rvalid_d  = 1'b1;
            arready_d = 1'b0;
            r_state_d = R_DATA;
         end
         R_DATA: if (rvalid_q && s_axi.rready) begin
            if (rlast_q) begin
               rvalid_d  = 1'b0;
               rlast_d   = 1'b0;
               arready_d = 1'b1;
               r_state_d = R_IDLE;
            end else begin
               r_word_d = r_nw;
               r_cnt_d  = r_cnt_q + LEN_WIDTH'(1);
               rdata_d  = r_err_q ? '0 : mem[r_nw];
               rlast_d  = (r_cnt_q + LEN_WIDTH'(1)) == r_len_q;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // state and output registers for both paths
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_state_q <= W_IDLE;  w_id_q <= '0;  w_word_q <= '0;  w_len_q <= '0;
         w_cnt_q   <= '0;      w_burst_q <= '0; w_err_q <= 1'b0;
         awready_q <= 1'b1;    wready_q <= 1'b0; bvalid_q <= 1'b0; bid_q <= '0; bresp_q <= '0;
         r_state_q <= R_IDLE;  r_id_q <= '0;  r_word_q <= '0;  r_len_q <= '0;
         r_cnt_q   <= '0;      r_burst_q <= '0; r_err_q <= 1'b0;
         arready_q <= 1'b1;    rvalid_q <= 1'b0; rid_q <= '0; rdata_q <= '0;
         rresp_q   <= '0;      rlast_q <= 1'b0;
      end else begin
         w_state_q <= w_state_d; w_id_q <= w_id_d; w_word_q <= w_word_d; w_len_q <= w_len_d;
         w_cnt_q   <= w_cnt_d;   w_burst_q <= w_burst_d; w_err_q <= w_err_d;
         awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
         bid_q     <= bid_d;     bresp_q <= bresp_d;
         r_state_q <= r_state_d; r_id_q <= r_id_d; r_word_q <= r_word_d; r_len_q <= r_len_d;
         r_cnt_q   <= r_cnt_d;   r_burst_q <= r_burst_d; r_err_q <= r_err_d;
         arready_q <= arready_d; rvalid_q <= rvalid_d; rid_q <= rid_d; rdata_q <= rdata_d;
         rresp_q   <= rresp_d;   rlast_q <= rlast_d;
      end
   end

   // byte-masked RAM write; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (s_axi.wstrb[i]) mem[w_word_q][8*i +: 8] <= s_axi.wdata[8*i +: 8];
         end
      end
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bid     = bid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rid     = rid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rlast   = rlast_q;
endmodule
